tl_a_echo_tracker: RTL
======================

// Module: tl_a_echo_tracker
// PURPOSE
//  Per-source tracker for TileLink-UL A-channel echo (prot) fields: captures a_echo on the first
//  beat of each A request and presents it with the matching D response, keyed by source ID.
//  Sits passively beside a TL A/D channel pair: observes fire events, never back-pressures.
//  Adds multi-beat awareness, protocol error flags and an outstanding-count output.
// PARAMETERS
//  SOURCE_BITS  4  width of a_source/d_source; table depth = 2**SOURCE_BITS
//  ECHO_W       3  width of the echo field (prot: bufferable/modifiable/privileged)
//  SIZE_BITS    4  width of a_size/d_size (log2 bytes)
//  BEAT_LOG2    3  log2 of data-bus bytes per beat
//  MAX_SIZE     6  largest legal log2 transfer size; larger sizes are treated as MAX_SIZE
// PORTS
//  clock           in   1                 clock
//  reset           in   1                 synchronous, active-high reset
//  a_valid         in   1                 A channel valid
//  a_ready         in   1                 A channel ready (A fire = a_valid & a_ready)
//  a_opcode        in   3                 0 PutFull, 1 PutPartial, 4 Get; others ignored
//  a_size          in   SIZE_BITS         log2 bytes of A message
//  a_source        in   SOURCE_BITS       A source ID
//  a_echo          in   ECHO_W            echo field to capture
//  d_valid         in   1                 D channel valid
//  d_ready         in   1                 D channel ready (D fire = d_valid & d_ready)
//  d_opcode        in   3                 0 AccessAck, 1 AccessAckData; others ignored
//  d_size          in   SIZE_BITS         log2 bytes of D message
//  d_source        in   SOURCE_BITS       D source ID
//  d_echo          out  ECHO_W            echo stored for d_source (combinational table read)
//  d_echo_valid    out  1                 entry for d_source is outstanding
//  outstanding     out  SOURCE_BITS+1     number of valid entries (registered)
//  err_dup         out  1                 pulse: A first beat hit an already-valid source
//  err_orphan      out  1                 pulse: D first beat hit an invalid source
//  err_sticky      out  1                 OR of all error pulses, held until reset
// BEHAVIOUR
//  - Reset: all table valid=0, echo=0; beat counters=0; outstanding=0; err_* = 0.
//  - Beats: data-bearing messages (A opcode 0/1, D opcode 1) with size>BEAT_LOG2 take
//    2**(size-BEAT_LOG2) beats; all others take 1. Counter width MAX_SIZE-BEAT_LOG2+1.
//  - One A counter, one D counter (beats of a message are contiguous per TL). Counter==0 marks
//    first beat; counter wraps to 0 on the last beat's fire. Only fires advance counters.
//  - A first-beat fire (legal opcode): entry[a_source] <= {valid=1, echo=a_echo} next cycle.
//    Later beats of the same message do not rewrite the entry.
//  - D last-beat fire (legal opcode): entry[d_source].valid <= 0 next cycle; echo retained.
//  - d_echo/d_echo_valid: zero-latency read of entry[d_source]; valid on every D beat.
//  - Same cycle, same source: D release and A allocate -> entry ends valid with new a_echo,
//    no err_dup; outstanding unchanged. Different sources: both applied; outstanding +1-1.
//  - err_dup: A first-beat fire with entry valid (and no same-cycle release) -> 1-cycle pulse the
//    next cycle; entry echo overwritten, outstanding not incremented.
//  - err_orphan: D first-beat fire with entry invalid (A alloc same cycle does not count) ->
//    1-cycle pulse next cycle; no release, outstanding not decremented.
//  - outstanding saturates neither way by construction; equals popcount of valid bits.
//  - Ignored opcodes: no table update, no counter advance, no error.
//  - Reset mid-burst: counters, table and flags return to reset values next cycle.
// TESTING
//  1. Get src 3 echo 5, AccessAckData size 6 (8 beats) -> d_echo=5, d_echo_valid=1 all 8 beats;
//     outstanding 1 -> 0 the cycle after beat 8.
//  2. PutFull size 6 src 2 echo 1, a_echo changed to 7 on beats 2-8 -> entry echo stays 1.
//  3. Get src 4 twice without D -> err_dup pulses once, outstanding=1, err_sticky=1 until reset.
//  4. AccessAck src 9 with no request -> err_orphan one cycle, outstanding stays 0.
//  5. D last beat src 6 and A Get src 6 echo 2 same cycle -> entry valid echo 2, no error,
//     outstanding unchanged.
//  6. All 16 sources requested, reset asserted during an 8-beat D burst -> next cycle
//     outstanding=0, d_echo_valid=0, counters at 0; new request then tracked normally.

Source files
------------

// File: rtl/tl_a_echo_tracker.sv
// tl_a_echo_tracker: captures the A-channel echo field per source ID and
// presents it alongside the matching D response, with protocol error flags.
module tl_a_echo_tracker #(
   parameter int SOURCE_BITS = 4,
   parameter int ECHO_W      = 3,
   parameter int SIZE_BITS   = 4,
   parameter int BEAT_LOG2   = 3,
   parameter int MAX_SIZE    = 6
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   a_valid,
   input  logic                   a_ready,
   input  logic [2:0]             a_opcode,
   input  logic [SIZE_BITS-1:0]   a_size,
   input  logic [SOURCE_BITS-1:0] a_source,
   input  logic [ECHO_W-1:0]      a_echo,
   input  logic                   d_valid,
   input  logic                   d_ready,
   input  logic [2:0]             d_opcode,
   input  logic [SIZE_BITS-1:0]   d_size,
   input  logic [SOURCE_BITS-1:0] d_source,
   output logic [ECHO_W-1:0]      d_echo,
   output logic                   d_echo_valid,
   output logic [SOURCE_BITS:0]   outstanding,
   output logic                   err_dup,
   output logic                   err_orphan,
   output logic                   err_sticky
);

   localparam int DEPTH = 2 ** SOURCE_BITS;
   localparam int CW    = MAX_SIZE - BEAT_LOG2 + 1;
   localparam int OW    = SOURCE_BITS + 1;

   localparam logic [SIZE_BITS-1:0] SZ_MAX  = SIZE_BITS'(MAX_SIZE);
   localparam logic [SIZE_BITS-1:0] SZ_BEAT = SIZE_BITS'(BEAT_LOG2);

   localparam logic [2:0] A_PUT_FULL = 3'd0;
   localparam logic [2:0] A_PUT_PART = 3'd1;
   localparam logic [2:0] A_GET      = 3'd4;
   localparam logic [2:0] D_ACK      = 3'd0;
   localparam logic [2:0] D_ACK_DATA = 3'd1;

   // Index of the final beat: 2**(size-BEAT_LOG2)-1 for data messages wider
   // than one beat, otherwise 0 (first beat is also the last).
   function automatic logic [CW-1:0] last_beat(
      input logic [SIZE_BITS-1:0] size,
      input logic                 data
   );
      logic [SIZE_BITS-1:0] s;
      logic [CW-1:0]        r;
      s = (size > SZ_MAX) ? SZ_MAX : size;
      r = '0;
      if (data && (s > SZ_BEAT)) begin
         r = (CW'(1) << (s - SZ_BEAT)) - CW'(1);
      end
      return r;
   endfunction

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ECHO_W-1:0] echo_q [DEPTH];
   logic [ECHO_W-1:0] echo_d [DEPTH];
   logic [CW-1:0]     a_cnt_q, a_cnt_d;
   logic [CW-1:0]     d_cnt_q, d_cnt_d;
   logic              d_orph_q, d_orph_d;
   logic              err_dup_q, err_dup_d;
   logic              err_orphan_q, err_orphan_d;
   logic              err_sticky_q, err_sticky_d;
   logic [OW-1:0]     outstanding_q, outstanding_d;

   logic          a_go, d_go;
   logic          a_first, d_first;
   logic [CW-1:0] a_last, d_last;
   logic          d_orph_msg;
   logic          rel;

   assign a_go = a_valid & a_ready &
                 ((a_opcode == A_PUT_FULL) |
                  (a_opcode == A_PUT_PART) |
                  (a_opcode == A_GET));
   assign d_go = d_valid & d_ready &
                 ((d_opcode == D_ACK) | (d_opcode == D_ACK_DATA));

   assign a_first = (a_cnt_q == '0);
   assign d_first = (d_cnt_q == '0);
   assign a_last  = last_beat(a_size, a_opcode != A_GET);
   assign d_last  = last_beat(d_size, d_opcode == D_ACK_DATA);

   // An orphaned response never releases, even if its source gets
   // allocated while the burst is still in flight.
   assign d_orph_msg = d_first ? ~valid_q[d_source] : d_orph_q;

   always_comb begin
      valid_d      = valid_q;
      echo_d       = echo_q;
      a_cnt_d      = a_cnt_q;
      d_cnt_d      = d_cnt_q;
      d_orph_d     = d_orph_q;
      err_dup_d    = 1'b0;
      err_orphan_d = 1'b0;
      rel          = 1'b0;

      if (d_go) begin
         d_cnt_d = (d_cnt_q == d_last) ? '0 : d_cnt_q + CW'(1);
         if (d_first) begin
            d_orph_d     = ~valid_q[d_source];
            err_orphan_d = ~valid_q[d_source];
         end
         if ((d_cnt_q == d_last) && !d_orph_msg) begin
            rel               = 1'b1;
            valid_d[d_source] = 1'b0;
         end
      end

      // Allocation is applied after release so a same-source hand-off wins.
      if (a_go) begin
         a_cnt_d = (a_cnt_q == a_last) ? '0 : a_cnt_q + CW'(1);
         if (a_first) begin
            err_dup_d = valid_q[a_source] &
                        ~(rel & (d_source == a_source));
            valid_d[a_source] = 1'b1;
            echo_d[a_source]  = a_echo;
         end
      end

      err_sticky_d = err_sticky_q | err_dup_d | err_orphan_d;
   end

   always_comb begin
      outstanding_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         outstanding_d = outstanding_d + OW'(valid_d[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q       <= '0;
         a_cnt_q       <= '0;
         d_cnt_q       <= '0;
         d_orph_q      <= 1'b0;
         err_dup_q     <= 1'b0;
         err_orphan_q  <= 1'b0;
         err_sticky_q  <= 1'b0;
         outstanding_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            echo_q[i] <= '0;
         end
      end else begin
         valid_q       <= valid_d;
         echo_q        <= echo_d;
         a_cnt_q       <= a_cnt_d;
         d_cnt_q       <= d_cnt_d;
         d_orph_q      <= d_orph_d;
         err_dup_q     <= err_dup_d;
         err_orphan_q  <= err_orphan_d;
         err_sticky_q  <= err_sticky_d;
         outstanding_q <= outstanding_d;
      end
   end

   assign d_echo       = echo_q[d_source];
   assign d_echo_valid = valid_q[d_source];
   assign outstanding  = outstanding_q;
   assign err_dup      = err_dup_q;
   assign err_orphan   = err_orphan_q;
   assign err_sticky   = err_sticky_q;

endmodule
